prince_ti_share_pipe: RTL and testbench



---
 rtl/prince_ti_pkg.sv | 32 +++
 rtl/prince_ti_skid.sv | 92 +++++++++
 rtl/prince_ti_share_pipe.sv | 95 +++++++++
 tb/tb_prince_ti_share_pipe.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prince_ti_pkg.sv
// Shared types and constants for the PRINCE threshold share pipeline stage.
// The optional TI_REFRESH_EN build adds share re-masking with fresh randomness at capture.
package prince_ti_pkg;

  localparam int NIB    = 16;
  localparam int W      = 4 * NIB;
  localparam int NSTAGE = 3;

  typedef logic [1:0]   stage_t;
  typedef logic [W-1:0] share_t;

  typedef struct packed {
    share_t s1;
    share_t s2;
    share_t s3;
    stage_t stage;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  // Occupancy of the skid buffer: nothing, main only, or main plus skid.
  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_MAIN  = 2'd1,
    SK_BOTH  = 2'd2
  } skid_state_t;

  function automatic stage_t stage_next(input stage_t s);
    return (s == stage_t'(NSTAGE - 1)) ? stage_t'(0) : s + stage_t'(1);
  endfunction

endpackage

// File: rtl/prince_ti_skid.sv
// Generic 2-entry valid/ready skid buffer: a main register drives the outputs,
// a skid register absorbs one beat while the main register is held.
module prince_ti_skid
  import prince_ti_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output skid_state_t   o_state
);

  // Handshake: a beat moves on any cycle where valid && ready; a producer never
  // waits for ready before raising valid, and holds data stable while valid && !ready.
  skid_state_t   r_state;
  logic [DW-1:0] r_main;
  logic [DW-1:0] r_skid;
  logic          r_valid;
  logic          r_ready;
  logic          w_acc;
  logic          w_emit;

  assign w_acc  = i_valid && r_ready;
  assign w_emit = r_valid && i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SK_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else if (i_clear) begin
      r_state <= SK_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        SK_EMPTY: begin
          if (w_acc) begin
            r_main  <= i_data;
            r_valid <= 1'b1;
            r_state <= SK_MAIN;
          end
        end
        SK_MAIN: begin
          if (w_acc && w_emit) begin
            r_main <= i_data;
          end else if (w_acc) begin
            r_skid  <= i_data;
            r_ready <= 1'b0;
            r_state <= SK_BOTH;
          end else if (w_emit) begin
            r_valid <= 1'b0;
            r_state <= SK_EMPTY;
          end
        end
        SK_BOTH: begin
          // in_ready is low here, so only the drain of the skid entry can happen.
          if (w_emit) begin
            r_main  <= r_skid;
            r_ready <= 1'b1;
            r_state <= SK_MAIN;
          end
        end
        default: begin
          r_state <= SK_EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_main;
  assign o_state = r_state;

  a_full_not_ready : assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == SK_BOTH) |-> !r_ready);
  a_valid_matches_state : assert property (@(posedge clk) disable iff (!rst_n)
    r_valid == (r_state != SK_EMPTY));

endmodule

// File: rtl/prince_ti_share_pipe.sv
// Registered three-share pipeline stage tagging each beat with its S-box decomposition stage.
// Define TI_REFRESH_EN to add the i_rnd port and re-mask the shares at capture.
module prince_ti_share_pipe
  import prince_ti_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [W-1:0]     i_in_s1,
  input  logic [W-1:0]     i_in_s2,
  input  logic [W-1:0]     i_in_s3,
`ifdef TI_REFRESH_EN
  input  logic [2*W-1:0]   i_rnd,
`endif
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [W-1:0]     o_out_s1,
  output logic [W-1:0]     o_out_s2,
  output logic [W-1:0]     o_out_s3,
  output logic [1:0]       o_out_stage
);

  stage_t      r_stage_cnt;
  beat_t       w_in_beat;
  beat_t       w_out_beat;
  logic        w_in_ready;
  logic        w_acc;
  skid_state_t w_dbg_state;

  assign w_acc = i_in_valid && w_in_ready && !i_clear;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_cnt <= '0;
    end else if (i_clear) begin
      r_stage_cnt <= '0;
    end else if (w_acc) begin
      r_stage_cnt <= stage_next(r_stage_cnt);
    end
  end

`ifdef TI_REFRESH_EN
  logic [W-1:0] w_r0;
  logic [W-1:0] w_r1;

  assign w_r0 = i_rnd[W-1:0];
  assign w_r1 = i_rnd[2*W-1:W];

  // s3 absorbs both masks so the XOR of the three shares is unchanged.
  always_comb begin
    w_in_beat       = '0;
    w_in_beat.s1    = i_in_s1 ^ w_r0;
    w_in_beat.s2    = i_in_s2 ^ w_r1;
    w_in_beat.s3    = i_in_s3 ^ w_r0 ^ w_r1;
    w_in_beat.stage = r_stage_cnt;
  end
`else
  always_comb begin
    w_in_beat       = '0;
    w_in_beat.s1    = i_in_s1;
    w_in_beat.s2    = i_in_s2;
    w_in_beat.s3    = i_in_s3;
    w_in_beat.stage = r_stage_cnt;
  end
`endif

  prince_ti_skid #(
    .DW (BEAT_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (i_clear),
    .i_valid (i_in_valid),
    .o_ready (w_in_ready),
    .i_data  (w_in_beat),
    .o_valid (o_out_valid),
    .i_ready (i_out_ready),
    .o_data  (w_out_beat),
    .o_state (w_dbg_state)
  );

  assign o_in_ready  = w_in_ready;
  assign o_out_s1    = w_out_beat.s1;
  assign o_out_s2    = w_out_beat.s2;
  assign o_out_s3    = w_out_beat.s3;
  assign o_out_stage = w_out_beat.stage;

  a_stage_in_range : assert property (@(posedge clk) disable iff (!rst_n)
    r_stage_cnt < stage_t'(NSTAGE));
  a_ready_tracks_skid : assert property (@(posedge clk) disable iff (!rst_n)
    w_in_ready == (w_dbg_state != SK_BOTH));

endmodule

// File: tb/tb_prince_ti_share_pipe.sv
// Self-checking bench for prince_ti_share_pipe: directed tables, hand sequences and
// random traffic checked against a FIFO-of-beats reference model (TI_REFRESH_EN aware).
module tb_prince_ti_share_pipe;
  import prince_ti_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         clr = 1'b0;
  logic         iv = 1'b0;
  logic         ordy = 1'b0;
  logic [W-1:0] s1 = '0;
  logic [W-1:0] s2 = '0;
  logic [W-1:0] s3 = '0;
`ifdef TI_REFRESH_EN
  logic [2*W-1:0] rnd = '0;
`endif
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] o1, o2, o3;
  logic [1:0]   ostage;

  prince_ti_share_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (clr),
    .i_in_valid  (iv),
    .o_in_ready  (in_ready),
    .i_in_s1     (s1),
    .i_in_s2     (s2),
    .i_in_s3     (s3),
`ifdef TI_REFRESH_EN
    .i_rnd       (rnd),
`endif
    .o_out_valid (out_valid),
    .i_out_ready (ordy),
    .o_out_s1    (o1),
    .o_out_s2    (o2),
    .o_out_s3    (o3),
    .o_out_stage (ostage)
  );

  // scoreboard
  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  int    m_cnt = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic beat_t model_beat();
    beat_t b;
    b.s1 = s1;
    b.s2 = s2;
    b.s3 = s3;
`ifdef TI_REFRESH_EN
    b.s1 = s1 ^ rnd[W-1:0];
    b.s2 = s2 ^ rnd[2*W-1:W];
    b.s3 = s3 ^ rnd[W-1:0] ^ rnd[2*W-1:W];
`endif
    b.stage = stage_t'(m_cnt);
    return b;
  endfunction

  // Model: an ordered store of at most two beats; ready while fewer than two are held.
  task automatic cycle();
    logic acc, emit;
    acc  = iv && (exp_q.size() < 2);
    emit = ordy && (exp_q.size() != 0);
    if (clr) begin
      exp_q.delete();
      m_cnt = 0;
    end else begin
      if (emit) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(model_beat());
        m_cnt = (m_cnt + 1) % NSTAGE;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", W'(out_valid), W'(exp_q.size() != 0));
    chk("in_ready", W'(in_ready), W'(exp_q.size() < 2));
    if (exp_q.size() != 0) begin
      chk("out_s1", o1, exp_q[0].s1);
      chk("out_s2", o2, exp_q[0].s2);
      chk("out_s3", o3, exp_q[0].s3);
      chk("out_stage", W'(ostage), W'(exp_q[0].stage));
    end
  endtask

  // driver helper: s2/s3 derived from s1 so all three share paths carry distinct data
  task automatic set_shares(input logic [W-1:0] v);
    s1 = v;
    s2 = {v[W/2-1:0], v[W-1:W/2]};
    s3 = ~v;
  endtask

  typedef struct {
    logic         clr;
    logic         iv;
    logic         ordy;
    logic [W-1:0] s1;
    logic         ev;
    logic         er;
    stage_t       estage;
    logic [W-1:0] es1;
  } vec_t;

  vec_t tbl[12];
  int   exp_tags[7];

  localparam logic [W-1:0] VA = 64'h1111_2222_3333_4444;
  localparam logic [W-1:0] VB = 64'h5555_6666_7777_8888;
  localparam logic [W-1:0] VC = 64'h9999_AAAA_BBBB_CCCC;
  localparam logic [W-1:0] VD = 64'hDDDD_EEEE_FFFF_0000;
  localparam logic [W-1:0] VE = 64'h0F0F_1E1E_2D2D_3C3C;
  localparam logic [W-1:0] VF = 64'h4B4B_5A5A_6969_7878;
  localparam logic [W-1:0] VG = 64'h8787_9696_A5A5_B4B4;
  localparam logic [W-1:0] VH = 64'hC3C3_D2D2_E1E1_F0F0;

  initial begin
    // backpressure A,B,C then clear with two beats stored and in_valid high
    tbl[0]  = '{1'b0, 1'b1, 1'b0, VA,   1'b1, 1'b1, 2'd0, VA};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, VB,   1'b1, 1'b0, 2'd0, VA};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, VC,   1'b1, 1'b0, 2'd0, VA};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, VC,   1'b1, 1'b1, 2'd1, VB};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, VC,   1'b1, 1'b1, 2'd2, VC};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, '0,   1'b0, 1'b1, 2'd0, '0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, VD,   1'b1, 1'b1, 2'd0, VD};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, VE,   1'b1, 1'b0, 2'd0, VD};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, VF,   1'b0, 1'b1, 2'd0, '0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, VG,   1'b0, 1'b1, 2'd0, '0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, VH,   1'b1, 1'b1, 2'd0, VH};
    tbl[11] = '{1'b0, 1'b0, 1'b1, '0,   1'b0, 1'b1, 2'd0, '0};
    exp_tags = '{0, 1, 2, 0, 1, 2, 0};

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_s1", o1, '0);
    chk("rst_s2", o2, '0);
    chk("rst_s3", o3, '0);
    chk("rst_stage", W'(ostage), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // single beat
    s1 = 64'h0123_4567_89AB_CDEF; s2 = '0; s3 = '0;
    iv = 1'b1; ordy = 1'b1;
    cycle();
    iv = 1'b0;
    chk("single_valid", W'(out_valid), W'(1));
    chk("single_s1", o1, 64'h0123_4567_89AB_CDEF);
    chk("single_s2", o2, '0);
    chk("single_s3", o3, '0);
    chk("single_stage", W'(ostage), '0);
    chk("single_ready", W'(in_ready), W'(1));
    cycle();
    chk("single_drained", W'(out_valid), '0);

    // streaming 7 beats from a zeroed counter
    clr = 1'b1; cycle(); clr = 1'b0;
    for (int i = 0; i < 7; i++) begin
      iv = 1'b1;
      set_shares({$urandom, $urandom});
      cycle();
      chk($sformatf("stream%0d_valid", i), W'(out_valid), W'(1));
      chk($sformatf("stream%0d_tag", i), W'(ostage), W'(exp_tags[i]));
    end
    iv = 1'b0;
    cycle();

    // table: backpressure and clear corner cases
    clr = 1'b1; cycle(); clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      clr = tbl[i].clr; iv = tbl[i].iv; ordy = tbl[i].ordy;
      set_shares(tbl[i].s1);
      cycle();
      chk($sformatf("tbl%0d_valid", i), W'(out_valid), W'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), W'(in_ready), W'(tbl[i].er));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_stage", i), W'(ostage), W'(tbl[i].estage));
        chk($sformatf("tbl%0d_s1", i), o1, tbl[i].es1);
      end
    end
    clr = 1'b0;

    // async reset mid-stream with two beats held
    iv = 1'b1; ordy = 1'b0;
    set_shares(VA); cycle();
    set_shares(VB); cycle();
    iv = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", W'(out_valid), '0);
    chk("arst_ready", W'(in_ready), W'(1));
    chk("arst_stage", W'(ostage), '0);
    chk("arst_s1", o1, '0);
    exp_q.delete();
    m_cnt = 0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    iv = 1'b1; ordy = 1'b1;
    set_shares(VC);
    cycle();
    chk("arst_first_tag", W'(ostage), '0);
    iv = 1'b0;
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      clr  = ($urandom_range(0, 99) < 3);
      s1 = {$urandom, $urandom};
      s2 = {$urandom, $urandom};
      s3 = {$urandom, $urandom};
`ifdef TI_REFRESH_EN
      rnd = {$urandom, $urandom, $urandom, $urandom};
`endif
      cycle();
    end
    clr = 1'b0; iv = 1'b0; ordy = 1'b1;
    cycle();
    cycle();

`ifdef TI_REFRESH_EN
    // refresh: r0 = low half, r1 = high half
    clr = 1'b1; cycle(); clr = 1'b0;
    s1 = '1; s2 = '0; s3 = '0;
    rnd = {64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555};
    iv = 1'b1; ordy = 1'b1;
    cycle();
    iv = 1'b0;
    chk("refresh_s1", o1, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("refresh_s2", o2, 64'hAAAA_AAAA_AAAA_AAAA);
    chk("refresh_s3", o3, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("refresh_xor", o1 ^ o2 ^ o3, 64'hFFFF_FFFF_FFFF_FFFF);
    cycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
